// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Mode and state encodings live here so the top and the bench agree on them.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    MODE_U8  = 2'd0,
    MODE_U7  = 2'd1,
    MODE_MOD = 2'd2,
    MODE_SAT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BLANK_DEFAULT = 4'hF;

  // 10^digits, the first value that no longer fits in the digit field.
  function automatic logic [63:0] pow10(input int digits);
    logic [63:0] result;
    result = 64'd1;
    for (int i = 0; i < digits; i++) begin
      result = result * 64'd10;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: digits of 5 or more get +3 before
// the shift so the doubled value carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one operand bit per clock,
// with operand masking, overflow flag, saturation and leading-zero blanking.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int         WIDTH  = 14,
  parameter int         DIGITS = 4,
  parameter logic [3:0] BLANK  = BLANK_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  input  logic [1:0]          sel,
  input  logic                blank_en,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf
);

  localparam int            AW        = 4 * DIGITS;
  localparam int            CW        = $clog2(WIDTH);
  localparam logic [63:0]   OVF_LIMIT = pow10(DIGITS);
  localparam logic [AW-1:0] BCD_RST   = {{(DIGITS-1){BLANK}}, 4'h0};
  localparam logic [AW-1:0] BCD_SAT   = {DIGITS{4'h9}};

  state_e          state, state_nx;
  logic [WIDTH-1:0] opr;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_adj;
  logic [CW-1:0]    count;
  mode_e            mode_q;
  logic             blank_q;
  logic             ovf_q;

  logic [WIDTH-1:0] bin_masked;
  logic             ovf_in;
  logic [AW-1:0]    bcd_sat;
  logic [AW-1:0]    bcd_fmt;

  assign busy = (state != IDLE);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    bin_masked = bin;
    case (mode_e'(sel))
      MODE_U8: bin_masked = WIDTH'(bin[7:0]);
      MODE_U7: bin_masked = WIDTH'(bin[6:0]);
      default: ;
    endcase
  end

  // Overflow is decided on the masked operand, not on the wrapped result.
  assign ovf_in = (64'(bin_masked) >= OVF_LIMIT);

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .digit    (acc[4*k +: 4]),
      .adjusted (acc_adj[4*k +: 4])
    );
  end

  always_comb begin
    bcd_sat = (mode_q == MODE_SAT && ovf_q) ? BCD_SAT : acc;
  end

  // Scan from the top digit down; digit 0 always shows, so zero reads as 0.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    bcd_fmt = bcd_sat;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (bcd_sat[4*k +: 4] != 4'h0) seen = 1'b1;
      if (blank_q && !seen) bcd_fmt[4*k +: 4] = BLANK;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (count == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opr     <= '0;
      acc     <= '0;
      count   <= '0;
      mode_q  <= MODE_U8;
      blank_q <= 1'b0;
      ovf_q   <= 1'b0;
      done    <= 1'b0;
      bcd     <= BCD_RST;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opr     <= bin_masked;
            acc     <= '0;
            count   <= CW'(WIDTH - 1);
            mode_q  <= mode_e'(sel);
            blank_q <= blank_en;
            ovf_q   <= ovf_in;
          end
        end
        SHIFT: begin
          // Bits pushed past the top digit fall away: result is mod 10^DIGITS.
          {acc, opr} <= {acc_adj, opr} << 1;
          if (count != '0) count <= count - 1'b1;
        end
        DONE: begin
          bcd  <= bcd_fmt;
          ovf  <= ovf_q;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
